fifo_rdstream: RTL and testbench
================================

FIFO_RDSTREAM -- requirements
Module: fifo_rdstream

Interface
REQ-001 The block SHALL have parameter DATABIT, default 8, giving the data word width.
REQ-002 The block SHALL have parameter RDLAT, default 1, giving the memory read latency in cycles; only the value 1 is supported.
REQ-003 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 Port rst_, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port notempty, input, 1 bit: the upstream FIFO controller holds at least one word.
REQ-006 Port fiford, output, 1 bit: read request to the upstream FIFO controller.
REQ-007 Port rddata, input, DATABIT bits: memory read data, valid RDLAT cycles after a cycle with fiford=1 and notempty=1.
REQ-008 Port flush, input, 1 bit: synchronous discard of all buffered and in-flight words.
REQ-009 Port dvalid, output, 1 bit: dout holds a valid word.
REQ-010 Port dready, input, 1 bit: the downstream consumer accepts dout this cycle.
REQ-011 Port dout, output, DATABIT bits: output data word.
REQ-012 Port occ, output, 2 bits: words stored plus words in flight (0..2).

Function
REQ-013 An issued read (iss) SHALL be fiford & notempty; a pop SHALL be dvalid & dready.
REQ-014 fiford SHALL be notempty & !flush & (occ<2 | pop); this is a combinational path from dready, notempty and flush to fiford.
REQ-015 A flag rv SHALL register iss; when rv=1, rddata SHALL be captured in that same cycle.
REQ-016 Storage SHALL be an output register (dout/dvalid) plus one skid register (skv/skd), giving 2 entries.
REQ-017 occ SHALL equal dvalid + skv + rv, and SHALL never exceed 2.
REQ-018 Returned data with rv=1 SHALL go to the output register if (!dvalid | pop) & !skv; otherwise it SHALL go to the skid register.
REQ-019 On a pop with skv=1, skd SHALL move to dout, skv SHALL clear, and any returning word SHALL enter the skid register.
REQ-020 Words SHALL leave dout strictly in issue order; no word is duplicated or lost.
REQ-021 Latency: an issue in cycle N SHALL give rv=1 in N+1 and dvalid=1 in N+2 when the stage is empty.
REQ-022 Throughput: with notempty=1 and dready=1 held, there SHALL be one pop per cycle after the initial 2-cycle fill.
REQ-023 While dvalid=1 and dready=0, dout SHALL hold stable.
REQ-024 When notempty=0, fiford SHALL be 0 and no read is issued; an upstream that is empty leaves occ unchanged except for pops.
REQ-025 Flush SHALL force fiford=0 in that cycle and clear dvalid, skv and rv on the next edge, dropping the in-flight word.
REQ-026 A pop coincident with flush SHALL still be consumed downstream.
REQ-027 With occ=2 and a pop, one issue SHALL be allowed, leaving occ=2.

Reset
REQ-028 When rst_=0, dvalid, skv and rv SHALL be 0, and dout and skd SHALL be 0, independent of clk.
REQ-029 During reset, fiford SHALL be 0 and occ SHALL be 0.
REQ-030 A reset asserted mid-operation SHALL discard all words; after release, the first issue SHALL wait for notempty.

Structure
REQ-031 RDLAT and the occ width SHALL come from the shared FIFO include used by the FIFO controller macros; no other shared typedefs are required.
REQ-032 The skid logic SHALL be one natural sub-module, fifo_skidreg: a 2-entry in-order register pair with valid/ready in and out.
REQ-033 The block SHALL connect directly to the FIFO controller's fiford/notempty and to the memory read port at the controller's rdaddr.

Verification
REQ-034 Load 4 words 0x11..0x44 upstream, hold dready=1 -> fiford high for 4 cycles; dout 0x11,0x22,0x33,0x44 on consecutive cycles, starting 2 cycles after the first fiford.
REQ-035 Load 5 words, hold dready=0 -> exactly 2 issues, occ=2, fiford=0; dout=first word and stable; after dready=1, all 5 words appear in order.
REQ-036 Toggle dready 1,0,1,0 with notempty=1 -> no loss and no duplication; occ never exceeds 2.
REQ-037 Assert flush one cycle after an issue with occ=2 -> next cycle dvalid=0, occ=0; the in-flight word never appears on dout.
REQ-038 Assert rst_=0 mid-stream with dvalid=1 -> dvalid=0, occ=0 and fiford=0 immediately (asynchronously); normal streaming resumes after release.
REQ-039 Run a single word with an upstream that is empty before and after -> one fiford pulse, dvalid for exactly one pop, then idle with occ=0.

Source files
------------

// File: rtl/fifo_rdstream_pkg.sv
// Shared FIFO constants used by the read-stream stage and the FIFO controller.
// The memory read latency and the occupancy width live here so both sides agree.
package fifo_rdstream_pkg;

    localparam int FIFO_RDLAT = 1;
    localparam int FIFO_OCCW  = 2;

    typedef logic [FIFO_OCCW-1:0] occ_t;

    localparam occ_t OCC_FULL = occ_t'(2);

endpackage

// File: rtl/fifo_skidreg.sv
// Two-entry in-order register pair: an output register backed by one skid register.
// The writer has no ready signal; its issue logic never sends a word without a free slot.
module fifo_skidreg
    import fifo_rdstream_pkg::*;
#(
    parameter int DATABIT = 8
)
(
    input  logic               clk,
    input  logic               rst_,
    input  logic               flush_i,
    input  logic               in_valid_i,
    input  logic [DATABIT-1:0] in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATABIT-1:0] out_data_o,
    output occ_t               count_o
);

    // Handshake: a word transfers out when out_valid_o & out_ready_i in the same cycle;
    // out_data_o is held stable while out_valid_o=1 and out_ready_i=0.
    logic               dv_q, dv_d;
    logic               skv_q, skv_d;
    logic [DATABIT-1:0] dout_q, dout_d;
    logic [DATABIT-1:0] skd_q, skd_d;
    logic               pop;

    assign pop         = dv_q & out_ready_i;
    assign out_valid_o = dv_q;
    assign out_data_o  = dout_q;
    assign count_o     = occ_t'(dv_q) + occ_t'(skv_q);

    always_comb begin
        dv_d   = dv_q;
        skv_d  = skv_q;
        dout_d = dout_q;
        skd_d  = skd_q;
        if (flush_i) begin
            dv_d  = 1'b0;
            skv_d = 1'b0;
        end else begin
            if (pop) begin
                if (skv_q) begin
                    dout_d = skd_q;
                    dv_d   = 1'b1;
                    skv_d  = 1'b0;
                end else begin
                    dv_d = 1'b0;
                end
            end
            // A returning word bypasses the skid only when nothing older is waiting there.
            if (in_valid_i) begin
                if ((!dv_q || pop) && !skv_q) begin
                    dout_d = in_data_i;
                    dv_d   = 1'b1;
                end else begin
                    skd_d = in_data_i;
                    skv_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            dv_q   <= 1'b0;
            skv_q  <= 1'b0;
            dout_q <= '0;
            skd_q  <= '0;
        end else begin
            dv_q   <= dv_d;
            skv_q  <= skv_d;
            dout_q <= dout_d;
            skd_q  <= skd_d;
        end
    end

endmodule

// File: rtl/fifo_rdstream.sv
// Turns a FIFO controller plus synchronous-read memory into a valid/ready stream.
// Reads are issued only while the two-entry stage has room for the returning word.
module fifo_rdstream
    import fifo_rdstream_pkg::*;
#(
    parameter int DATABIT = 8,
    parameter int RDLAT   = FIFO_RDLAT
)
(
    input  logic               clk,
    input  logic               rst_,
    input  logic               notempty,
    output logic               fiford,
    input  logic [DATABIT-1:0] rddata,
    input  logic               flush,
    output logic               dvalid,
    input  logic               dready,
    output logic [DATABIT-1:0] dout,
    output occ_t               occ
);

    // Only RDLAT=1 is supported: the occupancy count assumes one word in flight at most.
    logic [RDLAT-1:0] rv_q, rv_d;
    logic             rv;
    logic             iss;
    logic             pop;
    occ_t             skid_cnt;

    assign rv     = rv_q[RDLAT-1];
    assign pop    = dvalid & dready;
    assign occ    = skid_cnt + occ_t'(rv);
    assign fiford = rst_ & notempty & ~flush & ((occ < OCC_FULL) | pop);
    assign iss    = fiford & notempty;

    always_comb begin
        rv_d    = rv_q << 1;
        rv_d[0] = iss;
        if (flush) begin
            rv_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rv_q <= '0;
        end else begin
            rv_q <= rv_d;
        end
    end

    fifo_skidreg #(
        .DATABIT (DATABIT)
    ) u_skid (
        .clk         (clk),
        .rst_        (rst_),
        .flush_i     (flush),
        .in_valid_i  (rv),
        .in_data_i   (rddata),
        .out_valid_o (dvalid),
        .out_ready_i (dready),
        .out_data_o  (dout),
        .count_o     (skid_cnt)
    );

endmodule

// File: tb/tb_fifo_rdstream.sv
// Bench for fifo_rdstream: upstream FIFO and 1-cycle memory modelled with queues,
// expected stream behaviour tracked as an ordered list of issued-but-unconsumed words.
module tb_fifo_rdstream;

    localparam int W = 8;

    logic         clk;
    logic         rst_;
    logic         notempty;
    logic         fiford;
    logic [W-1:0] rddata;
    logic         flush;
    logic         dvalid;
    logic         dready;
    logic [W-1:0] dout;
    logic [1:0]   occ;

    fifo_rdstream #(.DATABIT(W), .RDLAT(1)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .notempty (notempty),
        .fiford   (fiford),
        .rddata   (rddata),
        .flush    (flush),
        .dvalid   (dvalid),
        .dready   (dready),
        .dout     (dout),
        .occ      (occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // upstream FIFO contents, words issued and not yet consumed, and both pop streams
    logic [W-1:0] up_q[$];
    logic [W-1:0] out_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mpop_q[$];
    int           inflight;
    int           n_checks;
    int           n_fail;

    logic         m_fiford, m_dvalid, m_pop;
    logic [1:0]   m_occ;
    logic [W-1:0] m_dout;
    logic         s_fiford, s_dvalid;
    logic [1:0]   s_occ;
    logic [W-1:0] s_dout;

    // One clock cycle: entered and left at the falling edge.
    task automatic cycle();
        logic [W-1:0] w;
        logic         iss;
        notempty = (up_q.size() != 0);
        #1;
        m_occ    = 2'(out_q.size());
        m_dvalid = (out_q.size() > inflight);
        m_dout   = '0;
        if (m_dvalid) m_dout = out_q[0];
        m_pop    = m_dvalid && dready;
        m_fiford = notempty && !flush && (m_occ < 2 || m_pop);
        s_fiford = fiford;
        s_dvalid = dvalid;
        s_dout   = dout;
        s_occ    = occ;
        iss = fiford && notempty;
        w   = '0;
        if (iss) w = up_q.pop_front();
        if (dvalid && dready) got_q.push_back(dout);
        if (m_pop) mpop_q.push_back(out_q[0]);
        @(posedge clk);
        if (flush) begin
            out_q.delete();
            inflight = 0;
        end else begin
            if (m_pop) void'(out_q.pop_front());
            inflight = 0;
            if (iss) begin
                out_q.push_back(w);
                inflight = 1;
            end
        end
        #1;
        rddata = iss ? w : W'($urandom);
        @(negedge clk);
    endtask

    task automatic drain();
        dready = 1'b1;
        flush  = 1'b0;
        for (int g = 0; g < 100 && (up_q.size() != 0 || out_q.size() != 0); g++) cycle();
        cycle();
    endtask

    task automatic clear_lists();
        got_q.delete();
        exp_q.delete();
        mpop_q.delete();
    endtask

    task automatic test_reset();
        rst_ = 1'b1; notempty = 1'b1; dready = 1'b1; flush = 1'b0; rddata = 8'hA5;
        inflight = 0;
        #1 rst_ = 1'b0;
        #1;
        n_checks += 4;
        if (dvalid !== 1'b0) begin n_fail++; $display("FAIL reset dvalid: got %b exp 0", dvalid); end
        if (occ !== 2'd0) begin n_fail++; $display("FAIL reset occ: got %0d exp 0", occ); end
        if (fiford !== 1'b0) begin n_fail++; $display("FAIL reset fiford: got %b exp 0", fiford); end
        if (dout !== 8'h00) begin n_fail++; $display("FAIL reset dout: got %h exp 00", dout); end
        repeat (2) @(negedge clk);
        n_checks += 2;
        if (dvalid !== 1'b0) begin n_fail++; $display("FAIL reset_clocked dvalid: got %b exp 0", dvalid); end
        if (fiford !== 1'b0) begin n_fail++; $display("FAIL reset_clocked fiford: got %b exp 0", fiford); end
        rst_ = 1'b1;
        notempty = 1'b0;
    endtask

    task automatic test_stream4();
        int first_rd, first_dv, n_rd;
        clear_lists();
        up_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        dready = 1'b1; flush = 1'b0;
        first_rd = -1; first_dv = -1; n_rd = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            n_checks += 3;
            if (s_fiford !== m_fiford) begin n_fail++; $display("FAIL stream4 fiford c%0d: got %b exp %b", c, s_fiford, m_fiford); end
            if (s_occ !== m_occ) begin n_fail++; $display("FAIL stream4 occ c%0d: got %0d exp %0d", c, s_occ, m_occ); end
            if (s_dvalid !== m_dvalid || (m_dvalid && s_dout !== m_dout)) begin n_fail++; $display("FAIL stream4 dout c%0d: got v=%b d=%h exp v=%b d=%h", c, s_dvalid, s_dout, m_dvalid, m_dout); end
            if (s_fiford) begin n_rd++; if (first_rd < 0) first_rd = c; end
            if (s_dvalid && first_dv < 0) first_dv = c;
        end
        n_checks += 2;
        if (n_rd != 4) begin n_fail++; $display("FAIL stream4 read_count: got %0d exp 4", n_rd); end
        if (first_dv != first_rd + 2) begin n_fail++; $display("FAIL stream4 latency: got dvalid at %0d exp %0d", first_dv, first_rd + 2); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stream4 pop_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream4 word%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n_rd;
        clear_lists();
        for (int i = 0; i < 5; i++) begin
            up_q.push_back(8'h60 + 8'(i * 7));
            exp_q.push_back(8'h60 + 8'(i * 7));
        end
        dready = 1'b0; flush = 1'b0; n_rd = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            n_checks += 2;
            if (s_fiford !== m_fiford) begin n_fail++; $display("FAIL backpressure fiford c%0d: got %b exp %b", c, s_fiford, m_fiford); end
            if (s_occ !== m_occ) begin n_fail++; $display("FAIL backpressure occ c%0d: got %0d exp %0d", c, s_occ, m_occ); end
            if (s_fiford) n_rd++;
            if (c >= 2) begin
                n_checks++;
                if (s_dvalid !== 1'b1 || s_dout !== exp_q[0]) begin n_fail++; $display("FAIL backpressure hold c%0d: got v=%b d=%h exp v=1 d=%h", c, s_dvalid, s_dout, exp_q[0]); end
            end
        end
        n_checks += 3;
        if (n_rd != 2) begin n_fail++; $display("FAIL backpressure issues: got %0d exp 2", n_rd); end
        if (s_occ !== 2'd2) begin n_fail++; $display("FAIL backpressure full_occ: got %0d exp 2", s_occ); end
        if (s_fiford !== 1'b0) begin n_fail++; $display("FAIL backpressure full_fiford: got %b exp 0", s_fiford); end
        dready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            n_checks += 2;
            if (s_fiford !== m_fiford) begin n_fail++; $display("FAIL backpressure_drain fiford c%0d: got %b exp %b", c, s_fiford, m_fiford); end
            if (s_dvalid !== m_dvalid || (m_dvalid && s_dout !== m_dout)) begin n_fail++; $display("FAIL backpressure_drain dout c%0d: got v=%b d=%h exp v=%b d=%h", c, s_dvalid, s_dout, m_dvalid, m_dout); end
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL backpressure pop_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL backpressure word%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_toggle();
        clear_lists();
        for (int i = 0; i < 8; i++) begin
            up_q.push_back(8'(($urandom & 32'h1f) << 3) | 8'(i));
            exp_q.push_back(up_q[i]);
        end
        flush = 1'b0;
        for (int c = 0; c < 16; c++) begin
            dready = (c % 2 == 0);
            cycle();
            n_checks += 4;
            if (s_fiford !== m_fiford) begin n_fail++; $display("FAIL toggle fiford c%0d: got %b exp %b", c, s_fiford, m_fiford); end
            if (s_occ !== m_occ) begin n_fail++; $display("FAIL toggle occ c%0d: got %0d exp %0d", c, s_occ, m_occ); end
            if (s_occ > 2'd2) begin n_fail++; $display("FAIL toggle occ_bound c%0d: got %0d exp <=2", c, s_occ); end
            if (s_dvalid !== m_dvalid || (m_dvalid && s_dout !== m_dout)) begin n_fail++; $display("FAIL toggle dout c%0d: got v=%b d=%h exp v=%b d=%h", c, s_dvalid, s_dout, m_dvalid, m_dout); end
        end
        drain();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL toggle pop_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle word%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] w[4];
        clear_lists();
        for (int i = 0; i < 4; i++) begin
            w[i] = 8'(($urandom & 32'h3f) << 2) | 8'(i);
            up_q.push_back(w[i]);
        end
        exp_q = '{w[2], w[3]};
        dready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            flush = (c == 2);
            cycle();
            n_checks += 2;
            if (s_fiford !== m_fiford) begin n_fail++; $display("FAIL flush fiford c%0d: got %b exp %b", c, s_fiford, m_fiford); end
            if (s_occ !== m_occ) begin n_fail++; $display("FAIL flush occ c%0d: got %0d exp %0d", c, s_occ, m_occ); end
        end
        n_checks += 2;
        if (s_dvalid !== 1'b0) begin n_fail++; $display("FAIL flush after_dvalid: got %b exp 0", s_dvalid); end
        if (s_occ !== 2'd0) begin n_fail++; $display("FAIL flush after_occ: got %0d exp 0", s_occ); end
        drain();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL flush pop_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL flush word%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        clear_lists();
        for (int c = 0; c < 400; c++) begin
            if (up_q.size() < 3 && $urandom_range(0, 2) != 0) up_q.push_back(W'($urandom));
            dready = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 24) == 0);
            cycle();
            n_checks += 3;
            if (s_fiford !== m_fiford) begin n_fail++; $display("FAIL random fiford c%0d: got %b exp %b", c, s_fiford, m_fiford); end
            if (s_occ !== m_occ) begin n_fail++; $display("FAIL random occ c%0d: got %0d exp %0d", c, s_occ, m_occ); end
            if (s_dvalid !== m_dvalid || (m_dvalid && s_dout !== m_dout)) begin n_fail++; $display("FAIL random dout c%0d: got v=%b d=%h exp v=%b d=%h", c, s_dvalid, s_dout, m_dvalid, m_dout); end
        end
        drain();
        n_checks++;
        if (got_q.size() != mpop_q.size()) begin n_fail++; $display("FAIL random pop_count: got %0d exp %0d", got_q.size(), mpop_q.size()); end
        else foreach (mpop_q[i]) begin
            n_checks++;
            if (got_q[i] !== mpop_q[i]) begin n_fail++; $display("FAIL random word%0d: got %h exp %h", i, got_q[i], mpop_q[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0] w[6];
        clear_lists();
        for (int i = 0; i < 6; i++) begin
            w[i] = 8'h90 + 8'(i);
            up_q.push_back(w[i]);
        end
        exp_q = '{w[0], w[3], w[4], w[5]};
        dready = 1'b1; flush = 1'b0;
        repeat (3) cycle();
        n_checks++;
        if (dvalid !== 1'b1) begin n_fail++; $display("FAIL reset_mid pre_dvalid: got %b exp 1", dvalid); end
        #2 rst_ = 1'b0;
        notempty = 1'b1;
        #1;
        n_checks += 3;
        if (dvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mid dvalid: got %b exp 0", dvalid); end
        if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_mid occ: got %0d exp 0", occ); end
        if (fiford !== 1'b0) begin n_fail++; $display("FAIL reset_mid fiford: got %b exp 0", fiford); end
        out_q.delete();
        inflight = 0;
        @(negedge clk);
        rst_ = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            n_checks += 3;
            if (s_fiford !== m_fiford) begin n_fail++; $display("FAIL reset_mid fiford c%0d: got %b exp %b", c, s_fiford, m_fiford); end
            if (s_occ !== m_occ) begin n_fail++; $display("FAIL reset_mid occ c%0d: got %0d exp %0d", c, s_occ, m_occ); end
            if (s_dvalid !== m_dvalid || (m_dvalid && s_dout !== m_dout)) begin n_fail++; $display("FAIL reset_mid dout c%0d: got v=%b d=%h exp v=%b d=%h", c, s_dvalid, s_dout, m_dvalid, m_dout); end
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL reset_mid pop_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL reset_mid word%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] wd;
        int n_rd;
        clear_lists();
        dready = 1'b1; flush = 1'b0; n_rd = 0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_checks += 2;
            if (s_fiford !== 1'b0) begin n_fail++; $display("FAIL single idle_fiford c%0d: got %b exp 0", c, s_fiford); end
            if (s_occ !== 2'd0) begin n_fail++; $display("FAIL single idle_occ c%0d: got %0d exp 0", c, s_occ); end
        end
        wd = W'($urandom);
        up_q.push_back(wd);
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (s_fiford) n_rd++;
            n_checks++;
            if (s_dvalid !== m_dvalid || (m_dvalid && s_dout !== m_dout)) begin n_fail++; $display("FAIL single dout c%0d: got v=%b d=%h exp v=%b d=%h", c, s_dvalid, s_dout, m_dvalid, m_dout); end
        end
        n_checks += 5;
        if (n_rd != 1) begin n_fail++; $display("FAIL single read_pulses: got %0d exp 1", n_rd); end
        if (got_q.size() != 1) begin n_fail++; $display("FAIL single pops: got %0d exp 1", got_q.size()); end
        else if (got_q[0] !== wd) begin n_fail++; $display("FAIL single word: got %h exp %h", got_q[0], wd); end
        if (s_occ !== 2'd0) begin n_fail++; $display("FAIL single end_occ: got %0d exp 0", s_occ); end
        if (s_dvalid !== 1'b0) begin n_fail++; $display("FAIL single end_dvalid: got %b exp 0", s_dvalid); end
        if (s_fiford !== 1'b0) begin n_fail++; $display("FAIL single end_fiford: got %b exp 0", s_fiford); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stream4();
        test_backpressure();
        test_toggle();
        test_flush();
        test_random();
        test_reset_midstream();
        test_single();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "simulation time limit");
    end

endmodule
